// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port SRAM between two requesters. Round-robin
//   arbitration, with optional locked (atomic) sequences of up to MAXLOCK
//   consecutive grants to one requester. Grants are combinational. Acks
//   pulse one cycle after acceptance, aligned with the SRAM's 1-cycle read
//   data.
//
// Ports
//   clock, resetn          : clock, synchronous active-low reset
//   req0/1, lock0/1        : request valid, keep the port after this grant
//   we0/1, addr0/1, wdata0/1 : per-requester byte enables, word address, data
//   gnt0/1                 : combinational grant (accepted when req & gnt)
//   ack0/1, rdata0/1       : completion pulse and read data per requester
//   mem_addr/we/wdata      : SRAM command, from the granted requester
//   mem_rdata              : SRAM read data, one cycle after the command
module mem_port_arbiter #(
  parameter int NBITS   = 32,
  parameter int AW      = 11,
  parameter int MAXLOCK = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [3:0]       we0,
  input  logic [3:0]       we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [NBITS-1:0] wdata0,
  input  logic [NBITS-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [NBITS-1:0] rdata0,
  output logic [NBITS-1:0] rdata1,
  output logic [AW-1:0]    mem_addr,
  output logic [3:0]       mem_we,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata
);

  localparam int CW = $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAXLOCK);
  // With MAXLOCK of 1 a lock request can never extend ownership.
  localparam bit LOCK_EN = (MAXLOCK > 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tag_valid_q, tag_valid_d;
  logic              tag_q, tag_d;
  logic [NBITS-1:0]  rdata0_q, rdata1_q;

  logic              win_vld_s;
  logic              win_s;
  logic              win_lock_s;
  logic [CW-1:0]     cnt_inc_s;

  // Winner selection for the current cycle; nothing is granted in reset.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = 1'b0;
    if (!resetn) begin
      win_vld_s = 1'b0;
      win_s     = 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (req0 && req1) begin
            win_vld_s = 1'b1;
            win_s     = ~last_gnt_q;
          end else if (req0) begin
            win_vld_s = 1'b1;
            win_s     = 1'b0;
          end else if (req1) begin
            win_vld_s = 1'b1;
            win_s     = 1'b1;
          end else begin
            win_vld_s = 1'b0;
            win_s     = 1'b0;
          end
        end
        ST_LOCK0: begin
          win_vld_s = req0;
          win_s     = 1'b0;
        end
        ST_LOCK1: begin
          win_vld_s = req1;
          win_s     = 1'b1;
        end
        default: begin
          win_vld_s = 1'b0;
          win_s     = 1'b0;
        end
      endcase
    end
  end

  assign gnt0       = win_vld_s & ~win_s;
  assign gnt1       = win_vld_s & win_s;
  assign win_lock_s = win_s ? lock1 : lock0;
  assign cnt_inc_s  = cnt_q + CW'(1);

  // Next-state: lock tracking, round-robin pointer and completion tag.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    tag_valid_d = 1'b0;
    tag_d       = tag_q;
    if (win_vld_s) begin
      last_gnt_d  = win_s;
      tag_valid_d = 1'b1;
      tag_d       = win_s;
      if (!win_lock_s) begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end else if (state_q == ST_ARB) begin
        if (LOCK_EN) begin
          state_d = win_s ? ST_LOCK1 : ST_LOCK0;
          cnt_d   = CW'(1);
        end else begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
      end else if (cnt_inc_s >= MAX_C) begin
        // Lock budget spent: last_gnt already points at the owner, so the
        // other requester wins the next contention.
        state_d = ST_ARB;
        cnt_d   = '0;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_inc_s;
      end
    end else begin
      // No winner while locked means the owner dropped its request.
      if (state_q != ST_ARB) begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_q;
      end
    end
  end

  // Acks come from the registered tag; masking with resetn suppresses the
  // ack of a request accepted just before reset asserts.
  assign ack0 = tag_valid_q & ~tag_q & resetn;
  assign ack1 = tag_valid_q & tag_q & resetn;

  // SRAM data is passed straight through on ack and captured for holding.
  assign rdata0 = ack0 ? mem_rdata : rdata0_q;
  assign rdata1 = ack1 ? mem_rdata : rdata1_q;

  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign mem_we    = gnt0 ? we0 : (gnt1 ? we1 : 4'b0000);

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_ARB;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_q       <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
      rdata0_q    <= ack0 ? mem_rdata : rdata0_q;
      rdata1_q    <= ack1 ? mem_rdata : rdata1_q;
    end
  end

endmodule
